// File: rtl/regfile_debug_master_pkg.sv
// -----------------------------------------------------------------------------
// regfile_debug_master_pkg
// Shared definitions for the debug-side register-file initiator:
//   INTERNAL_BITS  - machine word width (register data width)
//   REG_ADDR_BITS  - register index width (32-entry file)
//   CMD_DUMP/LOAD  - command opcodes carried on Cmd_op
//   ST_*           - FSM state encodings
// -----------------------------------------------------------------------------
package regfile_debug_master_pkg;

    localparam int INTERNAL_BITS = 32;
    localparam int REG_ADDR_BITS = 5;

    localparam logic CMD_DUMP = 1'b0;
    localparam logic CMD_LOAD = 1'b1;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_RD    = 3'd1;
    localparam state_t ST_CAP   = 3'd2;
    localparam state_t ST_OUT   = 3'd3;
    localparam state_t ST_LOAD  = 3'd4;
    localparam state_t ST_FLUSH = 3'd5;
    localparam state_t ST_DONE  = 3'd6;

endpackage

// File: rtl/regfile_debug_master_if.sv
// -----------------------------------------------------------------------------
// regfile_debug_master_if
// Debug-unit side channels of the register-file debug master:
//   command channel : Cmd_valid/Cmd_ready, Cmd_op, Cmd_start, Cmd_count
//   load stream     : Load_valid/Load_ready, Load_data
//   dump stream     : Dump_valid/Dump_ready, Dump_data, Dump_addr
// master modport = debug unit (issues commands, feeds loads, sinks dumps)
// slave  modport = regfile_debug_master
// -----------------------------------------------------------------------------
interface regfile_debug_master_if
    import regfile_debug_master_pkg::*;
#(
    parameter int DATA_BITS = INTERNAL_BITS,
    parameter int ADDR_BITS = REG_ADDR_BITS
);

    logic                 Cmd_valid;
    logic                 Cmd_ready;
    logic                 Cmd_op;
    logic [ADDR_BITS-1:0] Cmd_start;
    logic [ADDR_BITS:0]   Cmd_count;

    logic                 Load_valid;
    logic                 Load_ready;
    logic [DATA_BITS-1:0] Load_data;

    logic                 Dump_valid;
    logic                 Dump_ready;
    logic [DATA_BITS-1:0] Dump_data;
    logic [ADDR_BITS-1:0] Dump_addr;

    modport master (
        output Cmd_valid, Cmd_op, Cmd_start, Cmd_count,
        output Load_valid, Load_data,
        output Dump_ready,
        input  Cmd_ready, Load_ready, Dump_valid, Dump_data, Dump_addr
    );

    modport slave (
        input  Cmd_valid, Cmd_op, Cmd_start, Cmd_count,
        input  Load_valid, Load_data,
        input  Dump_ready,
        output Cmd_ready, Load_ready, Dump_valid, Dump_data, Dump_addr
    );

endinterface

// File: rtl/regfile_debug_master.sv
// -----------------------------------------------------------------------------
// regfile_debug_master
// Owns the register file's read/write ports while the core is halted and runs
// block dump/load commands over a contiguous, wrapping register range.
// Ports:
//   CLK, RST_n       - clock, asynchronous active-low reset
//   dbg              - command / load / dump channels (slave modport)
//   Rf_read_reg      - register file Read_reg1 (data returns one cycle later)
//   Rf_read_data     - register file Read_data1
//   Rf_write_*       - register file write port
//   Busy             - high whenever the FSM is not idle
//   Done             - one-cycle pulse at command completion
// All outputs are registered; the per-state strobes are computed from the
// next state so they line up with the state they describe.
// -----------------------------------------------------------------------------
module regfile_debug_master
    import regfile_debug_master_pkg::*;
#(
    parameter int DATA_BITS = INTERNAL_BITS,
    parameter int ADDR_BITS = REG_ADDR_BITS
) (
    input  logic                 CLK,
    input  logic                 RST_n,
    regfile_debug_master_if.slave dbg,
    output logic [ADDR_BITS-1:0] Rf_read_reg,
    input  logic [DATA_BITS-1:0] Rf_read_data,
    output logic                 Rf_write_enable,
    output logic [ADDR_BITS-1:0] Rf_write_reg,
    output logic [DATA_BITS-1:0] Rf_write_data,
    output logic                 Busy,
    output logic                 Done
);

    localparam logic [ADDR_BITS-1:0] PTR_ONE  = {{(ADDR_BITS-1){1'b0}}, 1'b1};
    localparam logic [ADDR_BITS:0]   CNT_ONE  = {{ADDR_BITS{1'b0}}, 1'b1};
    localparam logic [ADDR_BITS:0]   CNT_ZERO = {(ADDR_BITS+1){1'b0}};
    localparam logic [ADDR_BITS:0]   CNT_FULL = {1'b1, {ADDR_BITS{1'b0}}};

    state_t               state_r, state_nxt_s;
    logic [ADDR_BITS-1:0] ptr_r, ptr_nxt_s;
    logic [ADDR_BITS:0]   cnt_r, cnt_nxt_s;

    logic                 cmd_ready_r, load_ready_r, dump_valid_r;
    logic                 busy_r, done_r, wr_en_r;
    logic [ADDR_BITS-1:0] rd_reg_r, wr_reg_r, dump_addr_r;
    logic [DATA_BITS-1:0] wr_data_r, dump_data_r;

    logic                 cmd_fire_s, load_fire_s, dump_fire_s;

    // The ready/valid strobes are only high in their own state, so these
    // handshakes cannot fire anywhere else.
    assign cmd_fire_s  = dbg.Cmd_valid  & cmd_ready_r;
    assign load_fire_s = dbg.Load_valid & load_ready_r;
    assign dump_fire_s = dbg.Dump_ready & dump_valid_r;

    // Next-state, pointer and remaining-count logic.  The operation itself is
    // remembered by which branch (RD.. or LOAD) the FSM takes.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_fire_s) begin
                    ptr_nxt_s = dbg.Cmd_start;
                    if (dbg.Cmd_count == CNT_ZERO) begin
                        cnt_nxt_s = CNT_FULL;
                    end else begin
                        cnt_nxt_s = dbg.Cmd_count;
                    end
                    if (dbg.Cmd_op == CMD_LOAD) begin
                        state_nxt_s = ST_LOAD;
                    end else begin
                        state_nxt_s = ST_RD;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD:  state_nxt_s = ST_CAP;
            ST_CAP: state_nxt_s = ST_OUT;
            ST_OUT: begin
                if (dump_fire_s) begin
                    ptr_nxt_s = ptr_r + PTR_ONE;
                    cnt_nxt_s = cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_RD;
                    end
                end else begin
                    state_nxt_s = ST_OUT;
                end
            end
            ST_LOAD: begin
                if (load_fire_s) begin
                    ptr_nxt_s = ptr_r + PTR_ONE;
                    cnt_nxt_s = cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_nxt_s = ST_FLUSH;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_FLUSH: state_nxt_s = ST_DONE;
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state, wrapping address pointer and remaining word count.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_r <= ST_IDLE;
            ptr_r   <= {ADDR_BITS{1'b0}};
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Registered outputs: state strobes, read address, dump holding register
    // and the write port (which follows each load handshake by one cycle).
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            cmd_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            dump_valid_r <= 1'b0;
            load_ready_r <= 1'b0;
            rd_reg_r     <= {ADDR_BITS{1'b0}};
            dump_addr_r  <= {ADDR_BITS{1'b0}};
            dump_data_r  <= {DATA_BITS{1'b0}};
            wr_en_r      <= 1'b0;
            wr_reg_r     <= {ADDR_BITS{1'b0}};
            wr_data_r    <= {DATA_BITS{1'b0}};
        end else begin
            cmd_ready_r  <= (state_nxt_s == ST_IDLE);
            busy_r       <= (state_nxt_s != ST_IDLE);
            done_r       <= (state_nxt_s == ST_DONE);
            dump_valid_r <= (state_nxt_s == ST_OUT);
            load_ready_r <= (state_nxt_s == ST_LOAD);
            if (state_nxt_s == ST_RD) begin
                rd_reg_r <= ptr_nxt_s;
            end
            // Read data is valid the cycle after the address; hold it for OUT.
            if (state_r == ST_CAP) begin
                dump_data_r <= Rf_read_data;
                dump_addr_r <= ptr_r;
            end
            wr_en_r <= load_fire_s;
            if (load_fire_s) begin
                wr_reg_r  <= ptr_r;
                wr_data_r <= dbg.Load_data;
            end
        end
    end

    assign dbg.Cmd_ready  = cmd_ready_r;
    assign dbg.Load_ready = load_ready_r;
    assign dbg.Dump_valid = dump_valid_r;
    assign dbg.Dump_data  = dump_data_r;
    assign dbg.Dump_addr  = dump_addr_r;

    assign Rf_read_reg     = rd_reg_r;
    assign Rf_write_enable = wr_en_r;
    assign Rf_write_reg    = wr_reg_r;
    assign Rf_write_data   = wr_data_r;
    assign Busy            = busy_r;
    assign Done            = done_r;

endmodule

// File: tb/tb_regfile_debug_master.sv
// -----------------------------------------------------------------------------
// tb_regfile_debug_master
// Directed bench for regfile_debug_master with a small synchronous-read
// register file model attached to its Rf_* ports.
// -----------------------------------------------------------------------------
module tb_regfile_debug_master;
    import regfile_debug_master_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          CLK = 1'b0;
    logic          RST_n = 1'b0;
    logic [AW-1:0] Rf_read_reg;
    logic [DW-1:0] Rf_read_data;
    logic          Rf_write_enable;
    logic [AW-1:0] Rf_write_reg;
    logic [DW-1:0] Rf_write_data;
    logic          Busy;
    logic          Done;

    regfile_debug_master_if #(.DATA_BITS(DW), .ADDR_BITS(AW)) dbg ();

    regfile_debug_master #(.DATA_BITS(DW), .ADDR_BITS(AW)) dut (
        .CLK             (CLK),
        .RST_n           (RST_n),
        .dbg             (dbg),
        .Rf_read_reg     (Rf_read_reg),
        .Rf_read_data    (Rf_read_data),
        .Rf_write_enable (Rf_write_enable),
        .Rf_write_reg    (Rf_write_reg),
        .Rf_write_data   (Rf_write_data),
        .Busy            (Busy),
        .Done            (Done)
    );

    always #5 CLK = ~CLK;

    int checks;
    int errors;
    int cyc = 0;
    logic preload_req = 1'b1;

    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;

    ev_t dump_q[$];
    ev_t wr_q[$];
    int  hs_q[$];

    // Register file model: synchronous read, write on the clock edge.
    logic [DW-1:0] rf [0:31];
    always @(posedge CLK) begin
        Rf_read_data <= rf[Rf_read_reg];
        if (preload_req) begin
            for (int i = 0; i < 32; i++) rf[i] <= DW'(i);
        end else if (Rf_write_enable) begin
            rf[Rf_write_reg] <= Rf_write_data;
        end
    end

    always @(posedge CLK) cyc <= cyc + 1;

    // Log dump handshakes and register writes mid-cycle.
    always @(negedge CLK) begin
        if (dbg.Dump_valid && dbg.Dump_ready)
            dump_q.push_back({cyc, 27'd0, dbg.Dump_addr, dbg.Dump_data});
        if (Rf_write_enable)
            wr_q.push_back({cyc, 27'd0, Rf_write_reg, Rf_write_data});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    // Present a command at posedge+1 and hold it until taken (bounded).
    task automatic issue_cmd(input logic op, input logic [AW-1:0] start,
                             input logic [AW:0] count, output int acc);
        int n;
        n = 0;
        acc = -1;
        dbg.Cmd_valid = 1'b1;
        dbg.Cmd_op    = op;
        dbg.Cmd_start = start;
        dbg.Cmd_count = count;
        @(negedge CLK);
        while (!dbg.Cmd_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (dbg.Cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_accept: Cmd_ready=%b required 1", dbg.Cmd_ready);
        end else begin
            acc = cyc;
        end
        @(posedge CLK); #1;
        dbg.Cmd_valid = 1'b0;
    endtask

    // Dump with Dump_ready high on one cycle out of every `period`; tracks
    // whether the presented word stays stable across stalled cycles.
    task automatic run_dump(input logic [AW-1:0] start, input logic [AW:0] count,
                            input int period, output int c0, output int dc,
                            output int stalls, output int unstable);
        logic          prev_stall;
        logic [DW-1:0] pd;
        logic [AW-1:0] pa;
        dump_q.delete();
        wr_q.delete();
        dc = -1; stalls = 0; unstable = 0; prev_stall = 1'b0; pd = '0; pa = '0;
        dbg.Dump_ready = 1'b0;
        issue_cmd(CMD_DUMP, start, count, c0);
        for (int k = 0; k < 400; k++) begin
            dbg.Dump_ready = ((k % period) == 0);
            @(negedge CLK);
            if (dbg.Dump_valid && prev_stall && (dbg.Dump_data !== pd || dbg.Dump_addr !== pa))
                unstable++;
            prev_stall = dbg.Dump_valid && !dbg.Dump_ready;
            if (prev_stall) stalls++;
            pd = dbg.Dump_data;
            pa = dbg.Dump_addr;
            if (Done) begin
                dc = cyc;
                break;
            end
            @(posedge CLK); #1;
        end
        dbg.Dump_ready = 1'b0;
        if (dc < 0) begin
            checks++; errors++;
            $display("FAIL dump_timeout: Done not seen, required within 400 cycles");
        end
    endtask

    // Load the given words, offering Load_valid on cycles where pat is set.
    task automatic run_load(input logic [AW-1:0] start, input logic [AW:0] count,
                            input int words[$], input int pat[$],
                            output int c0, output int dc);
        int i;
        dump_q.delete();
        wr_q.delete();
        hs_q.delete();
        dc = -1; i = 0;
        issue_cmd(CMD_LOAD, start, count, c0);
        for (int k = 0; k < 400; k++) begin
            if (i < words.size() && pat[k % pat.size()] != 0) begin
                dbg.Load_valid = 1'b1;
                dbg.Load_data  = words[i];
            end else begin
                dbg.Load_valid = 1'b0;
            end
            @(negedge CLK);
            if (dbg.Load_valid && dbg.Load_ready) begin
                hs_q.push_back(cyc);
                i++;
            end
            if (Done) begin
                dc = cyc;
                break;
            end
            @(posedge CLK); #1;
        end
        dbg.Load_valid = 1'b0;
        if (dc < 0) begin
            checks++; errors++;
            $display("FAIL load_timeout: Done not seen, required within 400 cycles");
        end
    endtask

    task automatic test_reset();
        RST_n = 1'b0;
        preload_req = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if ({dbg.Cmd_ready, Busy, Done, dbg.Dump_valid, dbg.Load_ready, Rf_write_enable} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl: {rdy,busy,done,dv,lr,we}=%b required 100000",
                     {dbg.Cmd_ready, Busy, Done, dbg.Dump_valid, dbg.Load_ready, Rf_write_enable});
        end
        checks++;
        if ({Rf_read_reg, Rf_write_reg, dbg.Dump_addr} !== 15'd0) begin
            errors++;
            $display("FAIL reset_addr: rd=%0d wr=%0d dump=%0d required 0", Rf_read_reg, Rf_write_reg, dbg.Dump_addr);
        end
        checks++;
        if ({Rf_write_data, dbg.Dump_data} !== 64'd0) begin
            errors++;
            $display("FAIL reset_data: wr=%h dump=%h required 0", Rf_write_data, dbg.Dump_data);
        end
        preload_req = 1'b0;
        RST_n = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        checks++;
        if (dbg.Cmd_ready !== 1'b1 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: Cmd_ready=%b Busy=%b required 1 0", dbg.Cmd_ready, Busy);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_dump_all();
        int c0, dc, st, un;
        ev_t e;
        run_dump(5'd0, 6'd0, 1, c0, dc, st, un);
        checks++;
        if (dump_q.size() != 32) begin
            errors++;
            $display("FAIL dump_all_count: got %0d words required 32", dump_q.size());
        end
        for (int j = 0; j < dump_q.size(); j++) begin
            e = dump_q[j];
            checks++;
            if (e.a !== j || e.d !== j || e.cyc !== c0 + 3 + 3 * j) begin
                errors++;
                $display("FAIL dump_all_word%0d: addr=%0d data=%0d cyc=%0d required %0d %0d %0d",
                         j, e.a, e.d, e.cyc, j, j, c0 + 3 + 3 * j);
            end
        end
        checks++;
        if (dc !== c0 + 97) begin
            errors++;
            $display("FAIL dump_all_done: Done at %0d required %0d", dc - c0, 97);
        end
        checks++;
        if (wr_q.size() != 0) begin
            errors++;
            $display("FAIL dump_all_nowrite: %0d writes required 0", wr_q.size());
        end
        @(negedge CLK);
        checks++;
        if (Done !== 1'b0 || dbg.Cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL dump_all_idle: Done=%b Cmd_ready=%b required 0 1", Done, dbg.Cmd_ready);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_load_wrap();
        int c0, dc, st, un;
        int w[$];
        int pat[$];
        int exp_a[4] = '{30, 31, 0, 1};
        int exp_d[4] = '{100, 99, 98, 97};
        ev_t e;
        w.push_back(100); w.push_back(99); w.push_back(98); w.push_back(97);
        pat.push_back(1);
        run_load(5'd30, 6'd4, w, pat, c0, dc);
        checks++;
        if (hs_q.size() != 4 || wr_q.size() != 4) begin
            errors++;
            $display("FAIL load_wrap_count: hs=%0d writes=%0d required 4 4", hs_q.size(), wr_q.size());
        end
        for (int j = 0; j < 4 && j < hs_q.size() && j < wr_q.size(); j++) begin
            e = wr_q[j];
            checks++;
            if (hs_q[j] != c0 + 1 + j || e.a !== exp_a[j] || e.d !== exp_d[j] || e.cyc !== hs_q[j] + 1) begin
                errors++;
                $display("FAIL load_wrap_word%0d: hs=%0d reg=%0d data=%0d wcyc=%0d required hs=%0d reg=%0d data=%0d wcyc=%0d",
                         j, hs_q[j] - c0, e.a, e.d, e.cyc - c0, 1 + j, exp_a[j], exp_d[j], 2 + j);
            end
        end
        checks++;
        if (dc !== c0 + 6) begin
            errors++;
            $display("FAIL load_wrap_done: Done at %0d required 6", dc - c0);
        end
        @(negedge CLK);
        checks++;
        if (dbg.Cmd_ready !== 1'b1 || Rf_write_enable !== 1'b0) begin
            errors++;
            $display("FAIL load_wrap_idle: Cmd_ready=%b we=%b required 1 0", dbg.Cmd_ready, Rf_write_enable);
        end
        @(posedge CLK); #1;
        run_dump(5'd30, 6'd4, 1, c0, dc, st, un);
        checks++;
        if (dump_q.size() != 4) begin
            errors++;
            $display("FAIL load_readback_count: got %0d words required 4", dump_q.size());
        end
        for (int j = 0; j < dump_q.size() && j < 4; j++) begin
            e = dump_q[j];
            checks++;
            if (e.a !== exp_a[j] || e.d !== exp_d[j]) begin
                errors++;
                $display("FAIL load_readback%0d: addr=%0d data=%0d required %0d %0d", j, e.a, e.d, exp_a[j], exp_d[j]);
            end
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_dump_stall();
        int c0, dc, st, un;
        ev_t e;
        run_dump(5'd2, 6'd5, 3, c0, dc, st, un);
        checks++;
        if (st == 0 || un != 0) begin
            errors++;
            $display("FAIL dump_stall_hold: stalls=%0d unstable=%0d required >0 and 0", st, un);
        end
        checks++;
        if (dump_q.size() != 5) begin
            errors++;
            $display("FAIL dump_stall_count: got %0d words required 5", dump_q.size());
        end
        for (int j = 0; j < dump_q.size() && j < 5; j++) begin
            e = dump_q[j];
            checks++;
            if (e.a !== 2 + j || e.d !== 2 + j) begin
                errors++;
                $display("FAIL dump_stall_word%0d: addr=%0d data=%0d required %0d %0d", j, e.a, e.d, 2 + j, 2 + j);
            end
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_load_gaps();
        int c0, dc;
        int w[$];
        int pat[$];
        int exp_hs[3] = '{1, 4, 6};
        ev_t e;
        // Load_valid while idle must not cause any write.
        wr_q.delete();
        dbg.Load_valid = 1'b1;
        dbg.Load_data  = 32'hDEAD_BEEF;
        repeat (3) @(posedge CLK);
        #1;
        dbg.Load_valid = 1'b0;
        @(negedge CLK);
        checks++;
        if (wr_q.size() != 0) begin
            errors++;
            $display("FAIL load_idle_ignored: %0d writes required 0", wr_q.size());
        end
        @(posedge CLK); #1;
        w.push_back(7); w.push_back(8); w.push_back(9);
        pat.push_back(1); pat.push_back(0); pat.push_back(0);
        pat.push_back(1); pat.push_back(0); pat.push_back(1);
        run_load(5'd10, 6'd3, w, pat, c0, dc);
        checks++;
        if (hs_q.size() != 3 || wr_q.size() != 3) begin
            errors++;
            $display("FAIL load_gaps_count: hs=%0d writes=%0d required 3 3", hs_q.size(), wr_q.size());
        end
        for (int j = 0; j < 3 && j < hs_q.size() && j < wr_q.size(); j++) begin
            e = wr_q[j];
            checks++;
            if (hs_q[j] != c0 + exp_hs[j] || e.a !== 10 + j || e.d !== 7 + j || e.cyc !== c0 + exp_hs[j] + 1) begin
                errors++;
                $display("FAIL load_gaps_word%0d: hs=%0d reg=%0d data=%0d wcyc=%0d required hs=%0d reg=%0d data=%0d wcyc=%0d",
                         j, hs_q[j] - c0, e.a, e.d, e.cyc - c0, exp_hs[j], 10 + j, 7 + j, exp_hs[j] + 1);
            end
        end
        checks++;
        if (dc !== c0 + 8) begin
            errors++;
            $display("FAIL load_gaps_done: Done at %0d required 8", dc - c0);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_busy_cmd();
        int c0, dc, seen, bad;
        ev_t e;
        dump_q.delete();
        wr_q.delete();
        dc = -1; seen = 0; bad = 0;
        dbg.Dump_ready = 1'b1;
        issue_cmd(CMD_DUMP, 5'd5, 6'd2, c0);
        for (int k = 0; k < 100; k++) begin
            if (k >= 1 && k <= 3) begin
                dbg.Cmd_valid = 1'b1;
                dbg.Cmd_op    = CMD_LOAD;
                dbg.Cmd_start = 5'd0;
                dbg.Cmd_count = 6'd1;
            end else begin
                dbg.Cmd_valid = 1'b0;
            end
            @(negedge CLK);
            if (dbg.Cmd_valid) begin
                seen++;
                if (dbg.Cmd_ready !== 1'b0 || Busy !== 1'b1) bad++;
            end
            if (Done) begin
                dc = cyc;
                break;
            end
            @(posedge CLK); #1;
        end
        dbg.Cmd_valid  = 1'b0;
        dbg.Dump_ready = 1'b0;
        checks++;
        if (seen != 3 || bad != 0) begin
            errors++;
            $display("FAIL busy_cmd_ready: offered=%0d bad=%0d required 3 0", seen, bad);
        end
        checks++;
        if (dc !== c0 + 7) begin
            errors++;
            $display("FAIL busy_cmd_done: Done at %0d required 7", dc - c0);
        end
        checks++;
        if (dump_q.size() != 2 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL busy_cmd_count: words=%0d writes=%0d required 2 0", dump_q.size(), wr_q.size());
        end
        for (int j = 0; j < dump_q.size() && j < 2; j++) begin
            e = dump_q[j];
            checks++;
            if (e.a !== 5 + j || e.d !== 5 + j) begin
                errors++;
                $display("FAIL busy_cmd_word%0d: addr=%0d data=%0d required %0d %0d", j, e.a, e.d, 5 + j, 5 + j);
            end
        end
        @(negedge CLK);
        checks++;
        if (dbg.Cmd_ready !== 1'b1 || Busy !== 1'b0 || dbg.Load_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_cmd_idle: Cmd_ready=%b Busy=%b Load_ready=%b required 1 0 0",
                     dbg.Cmd_ready, Busy, dbg.Load_ready);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset_mid_load();
        int c0, dc, st, un;
        ev_t e;
        wr_q.delete();
        issue_cmd(CMD_LOAD, 5'd20, 6'd3, c0);
        dbg.Load_valid = 1'b1;
        dbg.Load_data  = 32'd555;
        @(negedge CLK);
        checks++;
        if (dbg.Load_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_load_ready: Load_ready=%b required 1", dbg.Load_ready);
        end
        @(posedge CLK); #1;
        dbg.Load_valid = 1'b0;
        checks++;
        if (Rf_write_enable !== 1'b1 || Rf_write_reg !== 5'd20) begin
            errors++;
            $display("FAIL rst_write_pending: we=%b reg=%0d required 1 20", Rf_write_enable, Rf_write_reg);
        end
        RST_n = 1'b0;
        #1;
        checks++;
        if ({dbg.Cmd_ready, Busy, Done, dbg.Dump_valid, dbg.Load_ready, Rf_write_enable} !== 6'b100000) begin
            errors++;
            $display("FAIL rst_mid_ctrl: {rdy,busy,done,dv,lr,we}=%b required 100000",
                     {dbg.Cmd_ready, Busy, Done, dbg.Dump_valid, dbg.Load_ready, Rf_write_enable});
        end
        checks++;
        if ({Rf_read_reg, Rf_write_reg, dbg.Dump_addr} !== 15'd0 || {Rf_write_data, dbg.Dump_data} !== 64'd0) begin
            errors++;
            $display("FAIL rst_mid_bus: rd=%0d wr=%0d da=%0d wd=%h dd=%h required all 0",
                     Rf_read_reg, Rf_write_reg, dbg.Dump_addr, Rf_write_data, dbg.Dump_data);
        end
        @(posedge CLK); #1;
        checks++;
        if (rf[20] !== 32'd20 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL rst_write_dropped: rf[20]=%0d writes=%0d required 20 0", rf[20], wr_q.size());
        end
        RST_n = 1'b1;
        @(negedge CLK);
        checks++;
        if (dbg.Cmd_ready !== 1'b1 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_release: Cmd_ready=%b Busy=%b required 1 0", dbg.Cmd_ready, Busy);
        end
        @(posedge CLK); #1;
        run_dump(5'd20, 6'd1, 1, c0, dc, st, un);
        checks++;
        if (dump_q.size() != 1) begin
            errors++;
            $display("FAIL rst_after_dump_count: got %0d words required 1", dump_q.size());
        end else begin
            e = dump_q[0];
            checks++;
            if (e.a !== 20 || e.d !== 20 || dc !== c0 + 4) begin
                errors++;
                $display("FAIL rst_after_dump: addr=%0d data=%0d done=%0d required 20 20 4", e.a, e.d, dc - c0);
            end
        end
        @(posedge CLK); #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        dbg.Cmd_valid  = 1'b0;
        dbg.Cmd_op     = 1'b0;
        dbg.Cmd_start  = '0;
        dbg.Cmd_count  = '0;
        dbg.Load_valid = 1'b0;
        dbg.Load_data  = '0;
        dbg.Dump_ready = 1'b0;
        test_reset();
        test_dump_all();
        test_load_wrap();
        test_dump_stall();
        test_load_gaps();
        test_busy_cmd();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
